// File: rtl/mem_arbiter.sv
// Two-master arbiter for the RAM8 data port: registered req/gnt ownership, MAX_HOLD-bounded runs, tagged read return.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking from idle (default: M0 wins ties).
module mem_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m0_mask,
  input  logic [1:0]  m1_mask,
  input  logic        m0_signed_ext,
  input  logic        m1_signed_ext,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] rdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [1:0]  ram_mask,
  output logic        ram_signed_ext,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [1:0]  dbg_owner,
  output logic [7:0]  dbg_hold_cnt
);

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_M0     = 2'd1;
  localparam logic [1:0] OWN_M1     = 2'd2;
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  logic [1:0] owner;
  logic [1:0] owner_nxt;
  logic [7:0] hold_cnt;
  logic [7:0] hold_inc;
  logic       acc0;
  logic       acc1;
  logic       rd0;
  logic       rd1;
  logic       tie_m1;

  // Handshake: a master raises req and keeps it high; gnt comes from the owner
  // register, and every cycle with gnt & req high is one access to RAM8.
  assign m0_gnt = (owner == OWN_M0);
  assign m1_gnt = (owner == OWN_M1);
  assign acc0   = m0_gnt & m0_req;
  assign acc1   = m1_gnt & m1_req;
  assign rd0    = acc0 & ~m0_we;
  assign rd1    = acc1 & ~m1_we;

  assign hold_inc = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;

  assign dbg_owner    = owner;
  assign dbg_hold_cnt = hold_cnt;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m1;

  // Most recent owner; starts as M1 so M0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_m1 <= 1'b1;
    end else if (owner_nxt == OWN_M0) begin
      last_m1 <= 1'b0;
    end else if (owner_nxt == OWN_M1) begin
      last_m1 <= 1'b1;
    end
  end

  assign tie_m1 = ~last_m1;
`else
  assign tie_m1 = 1'b0;
`endif

  always_comb begin
    owner_nxt = owner;
    case (owner)
      OWN_NONE: begin
        if (m0_req && m1_req) begin
          owner_nxt = tie_m1 ? OWN_M1 : OWN_M0;
        end else if (m0_req) begin
          owner_nxt = OWN_M0;
        end else if (m1_req) begin
          owner_nxt = OWN_M1;
        end
      end
      OWN_M0: begin
        // With req high while owning, this cycle is an access.
        if (!m0_req) begin
          owner_nxt = m1_req ? OWN_M1 : OWN_NONE;
        end else if ((hold_inc == HOLD_LIMIT) && m1_req && !m0_lock) begin
          owner_nxt = OWN_M1;
        end
      end
      OWN_M1: begin
        if (!m1_req) begin
          owner_nxt = m0_req ? OWN_M0 : OWN_NONE;
        end else if ((hold_inc == HOLD_LIMIT) && m0_req && !m1_lock) begin
          owner_nxt = OWN_M0;
        end
      end
      default: owner_nxt = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner    <= OWN_NONE;
      hold_cnt <= 8'd0;
    end else begin
      owner <= owner_nxt;
      if (owner_nxt != owner) begin
        hold_cnt <= 8'd0;
      end else if (acc0 || acc1) begin
        hold_cnt <= hold_inc;
      end
    end
  end

  // Read return: rvalid trails its access by one cycle regardless of ownership changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      m0_rvalid <= rd0;
      m1_rvalid <= rd1;
      if (rd0 || rd1) begin
        rdata <= ram_rdata;
      end
    end
  end

  // M0 drives the idle bus; writes are only ever issued inside an access cycle.
  always_comb begin
    ram_we         = (acc0 & m0_we) | (acc1 & m1_we);
    ram_addr       = m0_addr;
    ram_mask       = m0_mask;
    ram_signed_ext = m0_signed_ext;
    ram_wdata      = m0_wdata;
    if (acc1) begin
      ram_addr       = m1_addr;
      ram_mask       = m1_mask;
      ram_signed_ext = m1_signed_ext;
      ram_wdata      = m1_wdata;
    end
  end

endmodule
